// File: rtl/clb_param_if.sv
// rtl/clb_param_if.sv - configuration chain and logic I/O bundle of the parameterised CLB
interface clb_param_if #(
  parameter int K = 4,
  parameter int N = 2
);
  logic           prog_en;
  logic           prog_in;
  logic           prog_out;
  logic [N*K-1:0] clb_input;
  logic [N-1:0]   clb_output;
  logic           cfg_valid;
  logic           cfg_err;

  modport master (
    output prog_en, prog_in, clb_input,
    input  prog_out, clb_output, cfg_valid, cfg_err
  );

  modport slave (
    input  prog_en, prog_in, clb_input,
    output prog_out, clb_output, cfg_valid, cfg_err
  );
endinterface

// File: rtl/clb_param.sv
// rtl/clb_param.sv - N-BLE configurable logic block with K-input LUTs, serial config chain and commit check
module clb_param #(
  parameter int K = 4,
  parameter int N = 2
) (
  input  logic      clb_clk,
  input  logic      clb_rst_n,
  clb_param_if.slave bus
);
  localparam int LUT_SZ = 1 << K;
  localparam int W      = LUT_SZ + 2;
  localparam int TOTAL  = N * W;
  localparam int CW     = $clog2(TOTAL + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TOTAL + 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] active_q, active_d;
  logic [N-1:0]     ff_q, ff_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             cfg_err_q, cfg_err_d;
  logic             commit, commit_ok;
  logic [N-1:0]     lut_out;
  logic [N-1:0]     out_vec;

  always_ff @(posedge clb_clk or negedge clb_rst_n) begin
    if (!clb_rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      ff_q        <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      ff_q        <= ff_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    ff_d        = ff_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    commit      = 1'b0;
    commit_ok   = 1'b0;

    if (bus.prog_en) begin
      shadow_d = {bus.prog_in, shadow_q[TOTAL-1:1]};
    end

    case (state_q)
      IDLE: begin
        if (bus.prog_en) begin
          state_d = LOAD;
          count_d = CW'(1);
        end
      end
      LOAD: begin
        if (bus.prog_en) begin
          if (count_q != CNT_SAT) begin
            count_d = count_q + CW'(1);
          end
        end else begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    commit_ok = commit && (count_q == CNT_FULL);

    // A failed commit leaves the previously loaded function and its FF state intact.
    if (commit_ok) begin
      active_d    = shadow_q;
      cfg_valid_d = 1'b1;
      cfg_err_d   = 1'b0;
      for (int i = 0; i < N; i++) begin
        ff_d[i] = shadow_q[i*W + 1];
      end
    end else if (commit) begin
      cfg_err_d = 1'b1;
    end else if (cfg_valid_q && !bus.prog_en) begin
      ff_d = lut_out;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ble
    logic [LUT_SZ-1:0] lut_bits;
    logic [K-1:0]      sel;
    assign lut_bits   = active_q[i*W + 2 +: LUT_SZ];
    assign sel        = bus.clb_input[i*K +: K];
    assign lut_out[i] = lut_bits[sel];
    assign out_vec[i] = (cfg_valid_q && !bus.prog_en) ? (active_q[i*W] ? ff_q[i] : lut_out[i]) : 1'b0;
  end

  assign bus.clb_output = out_vec;
  assign bus.prog_out   = shadow_q[0];
  assign bus.cfg_valid  = cfg_valid_q;
  assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_clb_param.sv
// tb/tb_clb_param.sv - directed self-checking bench for clb_param at K=4/N=2 and K=6/N=1
module tb_clb_param;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  clb_param_if #(.K(4), .N(2)) a_if ();
  clb_param_if #(.K(6), .N(1)) b_if ();

  clb_param #(.K(4), .N(2)) dut_a (.clb_clk(clk), .clb_rst_n(rst_n), .bus(a_if.slave));
  clb_param #(.K(6), .N(1)) dut_b (.clb_clk(clk), .clb_rst_n(rst_n), .bus(b_if.slave));

  // BLE1 field: XOR4 LUT, ff_init=1, out_sel=1; BLE0 field: AND4 LUT, ff_init=0, out_sel=0
  localparam logic [127:0] CFG_A = {92'd0, 18'h1A65B, 18'h20000};
  localparam logic [127:0] CFG_B = 128'd1 << 65;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shift_in(input logic [127:0] d, input int n, input bit big);
    for (int i = 0; i < n; i++) begin
      if (big) begin
        b_if.prog_en = 1'b1;
        b_if.prog_in = d[i];
      end else begin
        a_if.prog_en = 1'b1;
        a_if.prog_in = d[i];
      end
      tick();
    end
  endtask

  task automatic load(input logic [127:0] d, input int n, input bit big);
    shift_in(d, n, big);
    a_if.prog_en = 1'b0;
    b_if.prog_en = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    n_cmp = 0;
    n_err = 0;
    a_if.prog_en = 1'b0; a_if.prog_in = 1'b0; a_if.clb_input = '0;
    b_if.prog_en = 1'b0; b_if.prog_in = 1'b0; b_if.clb_input = '0;

    #12;
    check("rst_out", a_if.clb_output, 0);
    check("rst_prog_out", a_if.prog_out, 0);
    check("rst_valid", a_if.cfg_valid, 0);
    check("rst_err", a_if.cfg_err, 0);
    rst_n = 1'b1;
    tick();

    load(CFG_A, 36, 0);
    check("load36_valid", a_if.cfg_valid, 1);
    check("load36_err", a_if.cfg_err, 0);
    check("first_cycle_out", a_if.clb_output, 2'b10);
    a_if.clb_input = 8'hFF;
    #1 check("and4_comb", a_if.clb_output, 2'b11);
    tick();
    check("xor4_reg_ff", a_if.clb_output, 2'b01);
    a_if.clb_input = 8'h1F;
    #1 check("ff_hold_1f", a_if.clb_output, 2'b01);
    tick();
    check("xor4_reg_1f", a_if.clb_output, 2'b11);
    a_if.clb_input = 8'h7E;
    #1 check("and4_zero_7e", a_if.clb_output, 2'b10);
    tick();
    check("xor4_reg_7e", a_if.clb_output, 2'b10);

    pulse_reset();
    a_if.clb_input = 8'hFF;
    load(CFG_A, 35, 0);
    check("short_err", a_if.cfg_err, 1);
    check("short_valid", a_if.cfg_valid, 0);
    check("short_out", a_if.clb_output, 0);
    load(CFG_A, 37, 0);
    check("long_err", a_if.cfg_err, 1);
    check("long_valid", a_if.cfg_valid, 0);
    load(CFG_A, 36, 0);
    check("reload_err", a_if.cfg_err, 0);
    check("reload_valid", a_if.cfg_valid, 1);

    tick();
    check("pre_reload_out", a_if.clb_output, 2'b01);
    shift_in({128{1'b1}}, 10, 0);
    check("mid_load_out", a_if.clb_output, 0);
    check("mid_load_valid", a_if.cfg_valid, 1);
    a_if.prog_en = 1'b0;
    tick();
    check("abort_err", a_if.cfg_err, 1);
    check("abort_valid", a_if.cfg_valid, 1);
    check("restored_out", a_if.clb_output, 2'b01);
    a_if.clb_input = 8'h1F;
    tick();
    check("restored_ff", a_if.clb_output, 2'b11);

    for (int s = 1; s <= 72; s++) begin
      a_if.prog_en = 1'b1;
      a_if.prog_in = ((s - 1) % 4) != 1;
      tick();
      if (s >= 36) begin
        check("prog_out_delay", a_if.prog_out, ((s - 36) % 4) != 1);
      end
    end
    a_if.prog_en = 1'b0;
    tick();
    check("sat_err", a_if.cfg_err, 1);

    pulse_reset();
    a_if.clb_input = 8'hFF;
    shift_in(CFG_A, 20, 0);
    a_if.prog_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_load_out", a_if.clb_output, 0);
    check("rst_load_valid", a_if.cfg_valid, 0);
    check("rst_load_prog_out", a_if.prog_out, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("no_commit_valid", a_if.cfg_valid, 0);
    check("no_commit_err", a_if.cfg_err, 0);
    load(CFG_A, 36, 0);
    check("op_out", a_if.clb_output, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("rst_op_out", a_if.clb_output, 0);
    check("rst_op_valid", a_if.cfg_valid, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_out", a_if.clb_output, 0);

    load(CFG_B, 66, 1);
    check("k6_valid", b_if.cfg_valid, 1);
    check("k6_err", b_if.cfg_err, 0);
    b_if.clb_input = 6'h3F;
    #1 check("k6_in_3f", b_if.clb_output, 1);
    b_if.clb_input = 6'h3E;
    #1 check("k6_in_3e", b_if.clb_output, 0);
    b_if.clb_input = 6'h1F;
    #1 check("k6_in_1f", b_if.clb_output, 0);
    b_if.clb_input = 6'h00;
    #1 check("k6_in_00", b_if.clb_output, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
